// File: rtl/cs_window_filter_pkg.sv
// Shared defaults and width helpers for the CS window filter.
package cs_pkg;

  localparam int unsigned CS_DATA_W    = 8;
  localparam int unsigned CS_WIN       = 9;
  localparam int unsigned CS_OUT_SHIFT = 3;

  // Running-sum width: holds WIN * (2^data_w - 1) without overflow.
  function automatic int unsigned cs_sum_w(input int unsigned data_w, input int unsigned win);
    return data_w + $clog2(win + 1);
  endfunction

  function automatic int unsigned cs_out_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/cs_window_filter_if.sv
// Sample/result bus of the CS window filter.
//   slave  : filter side (consumes in_valid/x_in/mode/flush, drives out_valid/y_out)
//   master : source/consumer side (the opposite directions)
interface cs_window_filter_if
  import cs_pkg::*;
#(
  parameter int unsigned DATA_W = CS_DATA_W,
  parameter int unsigned OUT_W  = cs_out_w(DATA_W)
);
  logic              in_valid;
  logic [DATA_W-1:0] x_in;
  logic              mode;
  logic              flush;
  logic              out_valid;
  logic [OUT_W-1:0]  y_out;

  modport slave (
    input  in_valid, x_in, mode, flush,
    output out_valid, y_out
  );

  modport master (
    output in_valid, x_in, mode, flush,
    input  out_valid, y_out
  );
endinterface

// File: rtl/cs_window_filter_appr_select.sv
// Combinational approximate-sample selection around the window average.
//   win_flat : WIN samples, entry i at [i*DATA_W +: DATA_W]
//   sum_new  : sum of the window contents
//   mode     : 0 = largest sample <= average, 1 = smallest sample >= average
//   appr     : selected sample value
module cs_appr_select
  import cs_pkg::*;
#(
  parameter int unsigned DATA_W = CS_DATA_W,
  parameter int unsigned WIN    = CS_WIN,
  parameter int unsigned SUM_W  = cs_sum_w(DATA_W, WIN)
) (
  input  logic [WIN*DATA_W-1:0] win_flat,
  input  logic [SUM_W-1:0]      sum_new,
  input  logic                  mode,
  output logic [DATA_W-1:0]     appr
);

  logic [DATA_W-1:0] w;
  logic [SUM_W-1:0]  scaled;

  // Comparing w*WIN against the sum is an exact test against the true
  // average without a divider. A qualifying sample always exists, so the
  // 0 / all-ones seeds never survive as the result.
  always_comb begin
    appr   = mode ? '1 : '0;
    w      = '0;
    scaled = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      w      = win_flat[i*DATA_W +: DATA_W];
      scaled = SUM_W'(w) * SUM_W'(WIN);
      if (!mode) begin
        if (scaled <= sum_new && w > appr) appr = w;
      end else begin
        if (scaled >= sum_new && w < appr) appr = w;
      end
    end
  end

endmodule

// File: rtl/cs_window_filter.sv
// CS window filter: sliding window of the last WIN accepted samples with a
// running sum; each accepted sample yields (sum + WIN*appr) >> OUT_SHIFT once
// the window is full.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sample input (in_valid, x_in, mode, flush) and result output
//           (out_valid, y_out)
module cs_window_filter
  import cs_pkg::*;
#(
  parameter int unsigned DATA_W    = CS_DATA_W,
  parameter int unsigned WIN       = CS_WIN,
  parameter int unsigned OUT_SHIFT = CS_OUT_SHIFT
) (
  input  logic           clk,
  input  logic           reset,
  cs_window_filter_if.slave bus
);

  localparam int unsigned SUM_W = cs_sum_w(DATA_W, WIN);
  localparam int unsigned OUT_W = cs_out_w(DATA_W);
  localparam int unsigned CNT_W = $clog2(WIN + 1);

  logic [DATA_W-1:0]     win_q [WIN];
  logic [DATA_W-1:0]     win_d [WIN];
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic [OUT_W-1:0]      y_q, y_d;
  logic                  out_valid_q, out_valid_d;

  logic [DATA_W-1:0]     win_new [WIN];
  logic [WIN*DATA_W-1:0] win_flat;
  logic [SUM_W-1:0]      sum_new;
  logic [CNT_W-1:0]      fill_new;
  logic [DATA_W-1:0]     appr;
  logic [SUM_W:0]        total;

  // Window as it looks after accepting x_in; entry 0 is the newest.
  always_comb begin
    win_flat   = '0;
    win_new[0] = bus.x_in;
    for (int unsigned i = 1; i < WIN; i++) win_new[i] = win_q[i-1];
    for (int unsigned i = 0; i < WIN; i++) win_flat[i*DATA_W +: DATA_W] = win_new[i];
    // The oldest entry is already part of sum_q, so this never underflows.
    sum_new  = sum_q + SUM_W'(bus.x_in) - SUM_W'(win_q[WIN-1]);
    fill_new = (fill_q == CNT_W'(WIN)) ? fill_q : fill_q + CNT_W'(1);
    total    = {1'b0, sum_new} + (SUM_W+1)'(WIN) * (SUM_W+1)'(appr);
  end

  cs_appr_select #(
    .DATA_W (DATA_W),
    .WIN    (WIN),
    .SUM_W  (SUM_W)
  ) u_appr_select (
    .win_flat (win_flat),
    .sum_new  (sum_new),
    .mode     (bus.mode),
    .appr     (appr)
  );

  always_comb begin
    win_d       = win_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      for (int unsigned i = 0; i < WIN; i++) win_d[i] = '0;
      sum_d       = '0;
      fill_d      = '0;
      y_d         = '0;
      out_valid_d = 1'b0;
    end else if (bus.in_valid) begin
      win_d  = win_new;
      sum_d  = sum_new;
      fill_d = fill_new;
      if (fill_new == CNT_W'(WIN)) begin
        y_d         = OUT_W'(total >> OUT_SHIFT);
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y_out     = y_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_cs_window_filter.sv
module tb_cs_window_filter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cs_window_filter_if #(.DATA_W(8), .OUT_W(10)) bus9 ();
  cs_window_filter_if #(.DATA_W(8), .OUT_W(10)) bus16 ();

  cs_window_filter #(.DATA_W(8), .WIN(9), .OUT_SHIFT(3)) u_dut9 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus9)
  );

  cs_window_filter #(.DATA_W(8), .WIN(16), .OUT_SHIFT(4)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model, one slot per instance (0: WIN=9/>>3, 1: WIN=16/>>4).
  int unsigned m_win   [2] = '{9, 16};
  int unsigned m_shift [2] = '{3, 4};
  int unsigned mw      [2][32];
  int unsigned msum    [2];
  int unsigned mfill   [2];
  int unsigned my      [2];
  bit          mvalid  [2];

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit fl, input bit v, input int unsigned x, input bit md);
    int unsigned old, appr, best;
    bit found;
    for (int k = 0; k < 2; k++) begin
      if (rst || fl) begin
        for (int j = 0; j < 32; j++) mw[k][j] = 0;
        msum[k] = 0; mfill[k] = 0; my[k] = 0; mvalid[k] = 0;
      end else if (v) begin
        old = mw[k][m_win[k]-1];
        for (int j = 31; j > 0; j--) mw[k][j] = mw[k][j-1];
        mw[k][0] = x;
        msum[k] = msum[k] + x - old;
        if (mfill[k] < m_win[k]) mfill[k]++;
        if (mfill[k] == m_win[k]) begin
          found = 0; best = 0;
          for (int j = 0; j < int'(m_win[k]); j++) begin
            if (!md && mw[k][j]*m_win[k] <= msum[k] && (!found || mw[k][j] > best)) begin best = mw[k][j]; found = 1; end
            if ( md && mw[k][j]*m_win[k] >= msum[k] && (!found || mw[k][j] < best)) begin best = mw[k][j]; found = 1; end
          end
          appr = best;
          my[k] = ((msum[k] + m_win[k]*appr) >> m_shift[k]) & 10'h3FF;
          mvalid[k] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] x, input bit md, input bit fl);
    bus9.in_valid = v;  bus9.x_in = x;  bus9.mode = md;  bus9.flush = fl;
    bus16.in_valid = v; bus16.x_in = x; bus16.mode = md; bus16.flush = fl;
    @(posedge clk);
    #1;
    model_update(1'b0, fl, v, x, md);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus9.in_valid = 0;  bus9.x_in = 0;  bus9.mode = 0;  bus9.flush = 0;
    bus16.in_valid = 0; bus16.x_in = 0; bus16.mode = 0; bus16.flush = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_update(1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    do_reset();
    chk("reset_valid", 10'(bus9.out_valid), 10'd0);
    chk("reset_y", bus9.y_out, 10'd0);

    // Nine samples of 10, mode 0.
    for (int i = 0; i < 8; i++) step(1, 8'h0A, 0, 0);
    chk("fill8_valid", 10'(bus9.out_valid), 10'd0);
    chk("fill8_y", bus9.y_out, 10'd0);
    step(1, 8'h0A, 0, 0);
    chk("fill9_valid", 10'(bus9.out_valid), 10'd1);
    chk("const10_y", bus9.y_out, 10'd22);

    // Window 1..8,12 (sum 48), mode 0 -> appr 5 -> 93>>3.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    step(1, 8'd12, 0, 0);
    chk("mode0_y", bus9.y_out, 10'd11);

    // Same window via flush, mode 1 -> appr 6 -> 102>>3.
    step(0, 8'd0, 0, 1);
    chk("flush_valid", 10'(bus9.out_valid), 10'd0);
    chk("flush_y", bus9.y_out, 10'd0);
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    step(1, 8'd12, 1, 0);
    chk("mode1_y", bus9.y_out, 10'd12);

    // Full-scale window: 9*255 = 2295, (2295+2295)>>3 = 573.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 8'hFF, 0, 0);
    chk("max_y", bus9.y_out, 10'd573);

    // Stall holds everything.
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h33, 1, 0);
      chk("stall_valid", 10'(bus9.out_valid), 10'd1);
      chk("stall_y", bus9.y_out, 10'd573);
    end
    // Accept 0: sum 2040, only 0 qualifies in mode 0 -> 2040>>3 = 255.
    step(1, 8'h00, 0, 0);
    chk("after_stall_y", bus9.y_out, 10'd255);

    // Mid-stream flush with a coincident sample that must be dropped.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 8'((i * 37) & 255), i[0], 0);
    chk("stream20_y", bus9.y_out, 10'(my[0]));
    step(1, 8'd99, 0, 1);
    chk("midflush_valid", 10'(bus9.out_valid), 10'd0);
    chk("midflush_y", bus9.y_out, 10'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i * 10), 1, 0);
      chk("refill_valid", 10'(bus9.out_valid), 10'd0);
    end
    // 10..90: sum 450, avg 50, mode 1 -> 50 -> 900>>3 = 112.
    step(1, 8'd90, 1, 0);
    chk("refill9_valid", 10'(bus9.out_valid), 10'd1);
    chk("refill9_y", bus9.y_out, 10'd112);

    // Mid-stream reset after 20 samples.
    for (int i = 0; i < 20; i++) step(1, 8'((i * 53 + 7) & 255), 0, 0);
    do_reset();
    chk("midreset_valid", 10'(bus9.out_valid), 10'd0);
    chk("midreset_y", bus9.y_out, 10'd0);

    // Random stream against the reference model, both configurations.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
      chk("rnd9_valid", 10'(bus9.out_valid), 10'(mvalid[0]));
      chk("rnd16_valid", 10'(bus16.out_valid), 10'(mvalid[1]));
      if (mvalid[0]) chk("rnd9_y", bus9.y_out, 10'(my[0]));
      if (mvalid[1]) chk("rnd16_y", bus16.y_out, 10'(my[1]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
